// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: execute-stage request/response bundle for the HI/LO
// multiply/divide engine (launch, cancel, mthi/mtlo, stall and results).
interface hilo_muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             cancel;
   logic             op_div;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, cancel, op_div, is_signed, a, b, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, cancel, op_div, is_signed, a, b, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide engine with HI/LO register pair.
// Multiply is radix-2 shift-add, divide is restoring shift-subtract; both run on
// operand magnitudes and apply signs in a single fix-up cycle.
module hilo_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   hilo_muldiv_unit_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   magB;
   logic               signA;
   logic               signB;
   logic               isDiv;
   logic [CW-1:0]      iterCnt;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic               busyReg;
   logic               doneReg;
   logic               dbzReg;

   logic               inSignA;
   logic               inSignB;
   logic [WIDTH-1:0]   inMagA;
   logic [WIDTH-1:0]   inMagB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic               divGeq;
   logic [WIDTH-1:0]   divDiff;
   logic [WIDTH-1:0]   fixQuo;
   logic [WIDTH-1:0]   fixRem;
   logic [2*WIDTH-1:0] mulStep;
   logic [2*WIDTH-1:0] divStep;
   logic [2*WIDTH-1:0] fixVal;

   assign bus.hi          = hiReg;
   assign bus.lo          = loReg;
   assign bus.busy        = busyReg;
   assign bus.done        = doneReg;
   assign bus.div_by_zero = dbzReg;

   // Operand conditioning: signs and magnitudes of the incoming operands.
   always_comb begin
      inSignA = bus.is_signed & bus.a[WIDTH-1];
      inSignB = bus.is_signed & bus.b[WIDTH-1];
      inMagA  = inSignA ? -bus.a : bus.a;
      inMagB  = inSignB ? -bus.b : bus.b;
   end

   // One iteration of each datapath, plus the sign fix-up of the final result.
   always_comb begin
      // Multiply: acc = {partial product, remaining multiplier bits}.
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? magB : {WIDTH{1'b0}})};
      mulStep  = {mulSum, acc[WIDTH-1:1]};
      // Divide: acc = {partial remainder, dividend/quotient bits}. The remainder
      // stays below magB, so the shifted value fits in WIDTH+1 bits and the
      // difference, when taken, fits in WIDTH bits.
      divShift = acc[2*WIDTH-1:WIDTH-1];
      divGeq   = divShift >= {1'b0, magB};
      divDiff  = divShift[WIDTH-1:0] - magB;
      divStep  = divGeq ? {divDiff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
      fixQuo   = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fixRem   = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fixVal   = isDiv ? {fixRem, fixQuo} : ((signA ^ signB) ? -acc : acc);
   end

   // Control FSM, datapath registers and HI/LO with registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         acc     <= '0;
         magB    <= '0;
         signA   <= 1'b0;
         signB   <= 1'b0;
         isDiv   <= 1'b0;
         iterCnt <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
         dbzReg  <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         dbzReg  <= 1'b0;
         // mthi/mtlo land in any state; result writes below take priority.
         if (bus.hi_we) hiReg <= bus.wdata;
         if (bus.lo_we) loReg <= bus.wdata;

         if (state == IDLE) begin
            if (bus.start && !bus.cancel) begin
               signA   <= inSignA;
               signB   <= inSignB;
               magB    <= inMagB;
               isDiv   <= bus.op_div;
               iterCnt <= '0;
               if (bus.op_div && (bus.b == '0)) begin
                  // Divide by zero: result is published immediately.
                  acc     <= {bus.a, {WIDTH{1'b1}}};
                  hiReg   <= bus.a;
                  loReg   <= '1;
                  doneReg <= 1'b1;
                  dbzReg  <= 1'b1;
                  state   <= DONE;
               end else begin
                  acc     <= {{WIDTH{1'b0}}, inMagA};
                  busyReg <= 1'b1;
                  state   <= CALC;
               end
            end
         end else if (bus.cancel) begin
            busyReg <= 1'b0;
            state   <= IDLE;
         end else begin
            case (state)
               CALC: begin
                  acc     <= isDiv ? divStep : mulStep;
                  iterCnt <= iterCnt + 1'b1;
                  if (iterCnt == CW'(WIDTH - 1)) state <= FIX;
               end
               FIX: begin
                  // Result is written on entry to DONE so it is readable the
                  // cycle busy drops, and rewritten in DONE so a concurrent
                  // mthi/mtlo cannot displace it.
                  acc     <= fixVal;
                  hiReg   <= fixVal[2*WIDTH-1:WIDTH];
                  loReg   <= fixVal[WIDTH-1:0];
                  busyReg <= 1'b0;
                  doneReg <= 1'b1;
                  state   <= DONE;
               end
               DONE: begin
                  hiReg <= acc[2*WIDTH-1:WIDTH];
                  loReg <= acc[WIDTH-1:0];
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vector table for the 32-bit engine, hand-written
// sequences for cancel, reset, write collisions and ignored start, and an 8-bit
// instance for the narrow-width case.
module tb_hilo_muldiv_unit;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   hilo_muldiv_unit_if #(.WIDTH(32)) bus32 ();
   hilo_muldiv_unit_if #(.WIDTH(8))  bus8 ();

   hilo_muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   hilo_muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

   typedef struct {
      string       name;
      logic        opDiv;
      logic        isSigned;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
      logic        expDz;
      int unsigned expLat;
   } vec_t;

   vec_t vecs[12];

   int unsigned nCompared   = 0;
   int unsigned nMismatched = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run32(input vec_t v);
      int unsigned cyc     = 1;
      int unsigned busyCnt = 0;
      bit          gotDone = 1'b0;
      bus32.op_div    = v.opDiv;
      bus32.is_signed = v.isSigned;
      bus32.a         = v.a;
      bus32.b         = v.b;
      bus32.start     = 1'b1;
      tick();
      bus32.start = 1'b0;
      while (!gotDone && cyc <= 100) begin
         if (bus32.done) gotDone = 1'b1;
         else begin
            if (bus32.busy) busyCnt++;
            tick();
            cyc++;
         end
      end
      check({v.name, "/done_seen"}, gotDone, 1);
      check({v.name, "/latency"}, cyc, v.expLat);
      check({v.name, "/busy_cycles"}, busyCnt, v.expLat - 1);
      check({v.name, "/busy_in_done"}, bus32.busy, 0);
      check({v.name, "/div_by_zero"}, bus32.div_by_zero, v.expDz);
      check({v.name, "/hi"}, bus32.hi, v.expHi);
      check({v.name, "/lo"}, bus32.lo, v.expLo);
      tick();
      check({v.name, "/done_pulse_end"}, bus32.done, 0);
   endtask

   task automatic run8(input string name, input logic opDiv, input logic isSigned,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] expHi,
                       input logic [7:0] expLo, input logic expDz, input int unsigned expLat);
      int unsigned cyc     = 1;
      bit          gotDone = 1'b0;
      bus8.op_div    = opDiv;
      bus8.is_signed = isSigned;
      bus8.a         = a;
      bus8.b         = b;
      bus8.start     = 1'b1;
      tick();
      bus8.start = 1'b0;
      while (!gotDone && cyc <= 40) begin
         if (bus8.done) gotDone = 1'b1;
         else begin
            tick();
            cyc++;
         end
      end
      check({name, "/done_seen"}, gotDone, 1);
      check({name, "/latency"}, cyc, expLat);
      check({name, "/div_by_zero"}, bus8.div_by_zero, expDz);
      check({name, "/hi"}, bus8.hi, expHi);
      check({name, "/lo"}, bus8.lo, expLo);
      tick();
   endtask

   initial begin
      int unsigned cyc;
      int unsigned doneCnt;
      int unsigned doneCyc;
      bit          sawDone;

      vecs[0]  = '{"mul_uu_max",    1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
      vecs[1]  = '{"mul_ss_m3x7",   1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
      vecs[2]  = '{"mul_uu_m3x7",   1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB, 1'b0, 34};
      vecs[3]  = '{"div_ss_m7d2",   1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
      vecs[4]  = '{"div_ss_minm1",  1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
      vecs[5]  = '{"div_uu_5d0",    1'b1, 1'b0, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
      vecs[6]  = '{"div_uu_100d7",  1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
      vecs[7]  = '{"div_ss_7dm2",   1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
      vecs[8]  = '{"mul_ss_m1xm1",  1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
      vecs[9]  = '{"div_ss_m5d0",   1'b1, 1'b1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1};
      vecs[10] = '{"div_uu_maxd16", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34};
      vecs[11] = '{"mul_ss_minmin", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};

      rst = 1'b0;
      {bus32.start, bus32.cancel, bus32.op_div, bus32.is_signed, bus32.hi_we, bus32.lo_we} = '0;
      bus32.a = '0; bus32.b = '0; bus32.wdata = '0;
      {bus8.start, bus8.cancel, bus8.op_div, bus8.is_signed, bus8.hi_we, bus8.lo_we} = '0;
      bus8.a = '0; bus8.b = '0; bus8.wdata = '0;
      tick();
      tick();
      check("reset/hi", bus32.hi, 0);
      check("reset/lo", bus32.lo, 0);
      check("reset/busy", bus32.busy, 0);
      check("reset/done", bus32.done, 0);
      check("reset/dz", bus32.div_by_zero, 0);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) run32(vecs[i]);

      // Cancel in cycle 10 of a multiply.
      bus32.wdata = 32'h11; bus32.hi_we = 1'b1;
      tick();
      bus32.hi_we = 1'b0; bus32.wdata = 32'h22; bus32.lo_we = 1'b1;
      tick();
      bus32.lo_we = 1'b0;
      check("preload/hi", bus32.hi, 32'h11);
      check("preload/lo", bus32.lo, 32'h22);
      bus32.op_div = 1'b0; bus32.is_signed = 1'b0; bus32.a = 32'd3; bus32.b = 32'd5;
      bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0;
      repeat (9) tick();
      check("cancel/busy_c10", bus32.busy, 1);
      bus32.cancel = 1'b1;
      tick();
      bus32.cancel = 1'b0;
      check("cancel/busy_c11", bus32.busy, 0);
      sawDone = 1'b0;
      repeat (40) begin
         if (bus32.done || bus32.busy) sawDone = 1'b1;
         tick();
      end
      check("cancel/no_done", sawDone, 0);
      check("cancel/hi", bus32.hi, 32'h11);
      check("cancel/lo", bus32.lo, 32'h22);

      // Reset in cycle 10 of a multiply.
      bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0;
      repeat (9) tick();
      rst = 1'b0;
      #1;
      check("midreset/busy", bus32.busy, 0);
      check("midreset/done", bus32.done, 0);
      check("midreset/hi", bus32.hi, 0);
      check("midreset/lo", bus32.lo, 0);
      tick();
      rst = 1'b1;
      sawDone = 1'b0;
      repeat (40) begin
         if (bus32.done) sawDone = 1'b1;
         tick();
      end
      check("midreset/no_done", sawDone, 0);

      // mthi during CALC is overwritten; mtlo in the done cycle loses.
      bus32.wdata = 32'h77; bus32.hi_we = 1'b1;
      tick();
      bus32.hi_we = 1'b0;
      bus32.op_div = 1'b1; bus32.is_signed = 1'b0; bus32.a = 32'd6; bus32.b = 32'd3;
      bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0;
      tick();
      tick();
      bus32.wdata = 32'h55; bus32.hi_we = 1'b1;
      tick();
      bus32.hi_we = 1'b0;
      check("collide/mthi_in_calc", bus32.hi, 32'h55);
      cyc = 4;
      while (!bus32.done && cyc <= 100) begin
         tick();
         cyc++;
      end
      check("collide/latency", cyc, 34);
      bus32.wdata = 32'hAA; bus32.lo_we = 1'b1;
      tick();
      bus32.lo_we = 1'b0;
      check("collide/lo", bus32.lo, 32'd2);
      check("collide/hi", bus32.hi, 32'd0);

      // start re-asserted in cycle 5 must be ignored.
      bus32.op_div = 1'b0; bus32.is_signed = 1'b0; bus32.a = 32'd3; bus32.b = 32'd5;
      bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0;
      repeat (4) tick();
      bus32.a = 32'd9; bus32.b = 32'd9; bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0;
      doneCnt = 0;
      doneCyc = 0;
      for (int c = 6; c <= 80; c++) begin
         if (bus32.done) begin
            doneCnt++;
            if (doneCyc == 0) doneCyc = c;
         end
         tick();
      end
      check("ignore_start/done_count", doneCnt, 1);
      check("ignore_start/done_cycle", doneCyc, 34);
      check("ignore_start/hi", bus32.hi, 32'd0);
      check("ignore_start/lo", bus32.lo, 32'd15);

      // Narrow instance.
      run8("w8_mul_uu_max",  1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 10);
      run8("w8_div_ss_minm1", 1'b1, 1'b1, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 10);
      run8("w8_div_uu_12d0", 1'b1, 1'b0, 8'h0C, 8'h00, 8'h0C, 8'hFF, 1'b1, 1);
      run8("w8_mul_ss_m3x7", 1'b0, 1'b1, 8'hFD, 8'h07, 8'hFF, 8'hEB, 1'b0, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
